// File: rtl/hybridcache_pkg.sv
// Shared types and entry layout for the hybridcache queue arbiters.
package hybridcache_pkg;

  // Arbiter control FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // A queue entry is {id, data}: payload in the low bits, requester id directly above it.
  localparam int ENTRY_DATA_LSB = 0;

  // Bit offset of the id field for a given payload width.
  function automatic int entry_id_lsb(input int databits);
    return databits;
  endfunction

endpackage

// File: rtl/queue_arbiter_rr_pick.sv
// Rotate-priority encoder: picks the first set request after position 'last', wrapping at N.
module rr_pick #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic          any,
  output logic [LW-1:0] idx
);

  logic [LW-1:0] cand;

  // Scan from the farthest candidate back to last+1 so the nearest set request wins.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = LW'((int'(last) + k) % N);
      if (req[cand]) begin
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/queue_arbiter.sv
// Shares one queue between NREQ requesters (round-robin push) and drains it through a
// one-entry output register, with an enable/drain FSM for quiescing before flush.
//
// Handshakes: the down side transfers an entry on every cycle where dn_valid && dn_ready
// are both high at the clock edge; dn_valid never drops and dn_id/dn_data never change
// while dn_valid && !dn_ready. On the request side req_ack is the one-cycle acceptance of
// req_data for the acked requester, coincident with queue_push.
module queue_arbiter
  import hybridcache_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int DATABITS = 8,
  parameter int IDBITS   = 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ctrl_enable,
  output logic                       ctrl_busy,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATABITS-1:0]   req_data,
  output logic [NREQ-1:0]            req_ack,
  output logic [IDBITS+DATABITS-1:0] queue_in,
  output logic                       queue_push,
  input  logic                       queue_warning,
  input  logic [IDBITS+DATABITS-1:0] queue_out,
  input  logic                       queue_not_empty,
  output logic                       queue_pop,
  output logic                       dn_valid,
  output logic [IDBITS-1:0]          dn_id,
  output logic [DATABITS-1:0]        dn_data,
  input  logic                       dn_ready
);

  localparam int ID_LSB = entry_id_lsb(DATABITS);

  state_t              state;
  state_t              state_nxt;
  logic [IDBITS-1:0]   rr_last;
  logic                pick_any;
  logic [IDBITS-1:0]   winner;
  logic                grant_ok;
  logic                load;

  rr_pick #(
    .N  (NREQ),
    .LW (IDBITS)
  ) u_rr_pick (
    .req  (req_valid),
    .last (rr_last),
    .any  (pick_any),
    .idx  (winner)
  );

  assign ctrl_busy = (state != ST_IDLE);
  assign grant_ok  = (state == ST_RUN) && !queue_warning && pick_any;
  assign load      = queue_not_empty && (!dn_valid || dn_ready) && (state != ST_IDLE);
  assign queue_pop = load;

  // Push side: steer the winning requester's payload into the queue and ack it.
  always_comb begin
    req_ack    = '0;
    queue_push = grant_ok;
    queue_in   = '0;
    queue_in[ENTRY_DATA_LSB +: DATABITS] = req_data[int'(winner)*DATABITS +: DATABITS];
    queue_in[ID_LSB +: IDBITS]           = winner;
    if (grant_ok) begin
      req_ack[winner] = 1'b1;
    end
  end

  // FSM next state: drain finishes only once both the queue and the output register are empty.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ctrl_enable) state_nxt = ST_RUN;
      ST_RUN:   if (!ctrl_enable) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (ctrl_enable) begin
          state_nxt = ST_RUN;
        end else if (!queue_not_empty && !dn_valid) begin
          state_nxt = ST_IDLE;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Round-robin pointer remembers the last requester that was granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_last <= IDBITS'(NREQ - 1);
    end else if (grant_ok) begin
      rr_last <= winner;
    end
  end

  // Output register: refill from the queue head whenever it is empty or being consumed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dn_valid <= 1'b0;
      dn_id    <= '0;
      dn_data  <= '0;
    end else if (load) begin
      dn_valid <= 1'b1;
      dn_id    <= queue_out[ID_LSB +: IDBITS];
      dn_data  <= queue_out[ENTRY_DATA_LSB +: DATABITS];
    end else if (dn_ready) begin
      dn_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_queue_arbiter.sv
// Bench for queue_arbiter: models the external queue, predicts grants and the drained entry
// stream from the arbitration rules, and checks the down-side stream in a separate monitor.
module tb_queue_arbiter;

  localparam int NREQ     = 4;
  localparam int DATABITS = 8;
  localparam int IDBITS   = 2;
  localparam int EW       = IDBITS + DATABITS;
  localparam int WARN_LVL = 6;

  // ---------------- clock / reset ----------------
  logic                     clk;
  logic                     reset_n;
  logic                     ctrl_enable;
  logic                     ctrl_busy;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ*DATABITS-1:0] req_data;
  logic [NREQ-1:0]          req_ack;
  logic [EW-1:0]            queue_in;
  logic                     queue_push;
  logic                     queue_warning;
  logic [EW-1:0]            queue_out;
  logic                     queue_not_empty;
  logic                     queue_pop;
  logic                     dn_valid;
  logic [IDBITS-1:0]        dn_id;
  logic [DATABITS-1:0]      dn_data;
  logic                     dn_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  queue_arbiter #(
    .NREQ     (NREQ),
    .DATABITS (DATABITS),
    .IDBITS   (IDBITS)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ctrl_enable     (ctrl_enable),
    .ctrl_busy       (ctrl_busy),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ack         (req_ack),
    .queue_in        (queue_in),
    .queue_push      (queue_push),
    .queue_warning   (queue_warning),
    .queue_out       (queue_out),
    .queue_not_empty (queue_not_empty),
    .queue_pop       (queue_pop),
    .dn_valid        (dn_valid),
    .dn_id           (dn_id),
    .dn_data         (dn_data),
    .dn_ready        (dn_ready)
  );

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0]       fifo[$];    // contents of the external queue
  logic [EW-1:0]       exp_q[$];   // entries expected on the down side, in order
  int                  checks;
  int                  errors;
  int                  m_state;    // 0 idle, 1 run, 2 drain
  int                  m_last;
  bit                  m_dn_valid;
  bit                  force_warn;
  logic [NREQ-1:0]     last_ack;
  bit                  prev_hold;
  logic [EW-1:0]       prev_dn;
  logic [EW-1:0]       mon_exp;
  logic [EW-1:0]       t5_dn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic set_warn(input bit b);
    force_warn    = b;
    queue_warning = b || (fifo.size() >= WARN_LVL);
  endtask

  // One clock cycle: check at the falling edge, advance the model, then present the queue's
  // new state shortly after the rising edge. Inputs are changed by callers after return.
  task automatic cycle();
    int              w;
    bit              grant;
    bit              e_pop;
    bit              fifo_ne;
    bit              dn_pre;
    logic [NREQ-1:0] e_ack;
    logic [EW-1:0]   e_entry;
    @(negedge clk);
    if (!reset_n) begin
      chk("rst_ack",     32'(req_ack),    32'(0));
      chk("rst_push",    32'(queue_push), 32'(0));
      chk("rst_pop",     32'(queue_pop),  32'(0));
      chk("rst_busy",    32'(ctrl_busy),  32'(0));
      chk("rst_dn_valid", 32'(dn_valid),  32'(0));
      chk("rst_dn_id",   32'(dn_id),      32'(0));
      chk("rst_dn_data", 32'(dn_data),    32'(0));
      m_state    = 0;
      m_last     = NREQ - 1;
      m_dn_valid = 1'b0;
      prev_hold  = 1'b0;
      last_ack   = '0;
      fifo.delete();
      exp_q.delete();
    end else begin
      fifo_ne = (fifo.size() > 0);
      dn_pre  = m_dn_valid;
      grant   = (m_state == 1) && !queue_warning && (req_valid != '0);
      w       = 0;
      e_ack   = '0;
      if (grant) begin
        for (int k = 1; k <= NREQ; k++) begin
          int c;
          c = (m_last + k) % NREQ;
          if (req_valid[c]) begin
            w = c;
            break;
          end
        end
        e_ack = NREQ'(1 << w);
      end
      e_entry = {w[IDBITS-1:0], req_data[w*DATABITS +: DATABITS]};
      e_pop   = fifo_ne && (!m_dn_valid || dn_ready) && (m_state != 0);

      chk("req_ack",    32'(req_ack),    32'(e_ack));
      chk("queue_push", 32'(queue_push), 32'(grant));
      if (grant) chk("queue_in", 32'(queue_in), 32'(e_entry));
      chk("queue_pop",  32'(queue_pop),  32'(e_pop));
      chk("ctrl_busy",  32'(ctrl_busy),  32'(m_state != 0));
      chk("dn_valid",   32'(dn_valid),   32'(m_dn_valid));
      if (prev_hold) chk("dn_hold", 32'({dn_id, dn_data}), 32'(prev_dn));
      last_ack = req_ack;

      // the external queue reacts to what the DUT actually strobes
      if (queue_pop && fifo.size() > 0) void'(fifo.pop_front());
      if (queue_push) fifo.push_back(queue_in);

      if (grant) begin
        exp_q.push_back(e_entry);
        m_last = w;
      end
      prev_hold = dn_valid && !dn_ready;
      prev_dn   = {dn_id, dn_data};
      if (e_pop) m_dn_valid = 1'b1;
      else if (dn_ready) m_dn_valid = 1'b0;

      case (m_state)
        0: if (ctrl_enable) m_state = 1;
        1: if (!ctrl_enable) m_state = 2;
        2: if (ctrl_enable) m_state = 1;
           else if (!fifo_ne && !dn_pre) m_state = 0;
        default: m_state = 0;
      endcase
    end
    @(posedge clk);
    #1;
    queue_not_empty = (fifo.size() > 0);
    queue_out       = (fifo.size() > 0) ? fifo[0] : '0;
    queue_warning   = force_warn || (fifo.size() >= WARN_LVL);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // ---------------- monitor: down-side stream ----------------
  always @(negedge clk) begin
    if (reset_n && dn_valid && dn_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dn_unexpected actual=%0h required=no_entry at %0t", {dn_id, dn_data}, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("dn_entry", 32'({dn_id, dn_data}), 32'(mon_exp));
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  logic [NREQ-1:0] t1_tab [5];
  logic [NREQ-1:0] t2_tab [3];

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; ctrl_enable = 1'b0; req_valid = '0; req_data = '0; dn_ready = 1'b0;
    queue_out = '0; queue_not_empty = 1'b0; force_warn = 1'b0; queue_warning = 1'b0;
    last_ack = '0; prev_hold = 1'b0; prev_dn = '0;
    t1_tab[0] = 4'b0001; t1_tab[1] = 4'b0010; t1_tab[2] = 4'b0100; t1_tab[3] = 4'b1000; t1_tab[4] = 4'b0001;
    t2_tab[0] = 4'b0100; t2_tab[1] = 4'b0001; t2_tab[2] = 4'b0100;
    #2;
    cycles(3);
    reset_n = 1'b1;

    // T1: all requesting -> strict rotation starting at 0 and wrapping
    ctrl_enable = 1'b1; dn_ready = 1'b1;
    req_valid = 4'b1111; req_data = 32'h44332211;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t1_ack", 32'(last_ack), 32'(t1_tab[i]));
    end

    // T2: sparse requests from rr_last=0
    req_valid = 4'b0101; req_data = 32'h00CC00AA;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t2_ack", 32'(last_ack), 32'(t2_tab[i]));
    end

    // T3: fill a little, then hold warning with requests pending while pops continue
    dn_ready = 1'b0; req_valid = 4'b1111; req_data = 32'h5A6B7C8D;
    cycles(3);
    dn_ready = 1'b1;
    set_warn(1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t3_blocked", 32'(last_ack), 32'(0));
    end
    set_warn(1'b0);
    cycle();
    chk("t3_resume", 32'(last_ack != '0), 32'(1));

    // T4: single push into an empty queue shows up two edges later for one cycle
    req_valid = '0;
    cycles(6);
    req_valid = 4'b1000; req_data = 32'hA5000000;
    cycle();
    req_valid = '0;
    cycle();
    chk("t4_dn_valid", 32'(dn_valid), 32'(1));
    chk("t4_dn_id",    32'(dn_id),    32'(3));
    chk("t4_dn_data",  32'(dn_data),  32'(8'hA5));
    cycle();
    chk("t4_dn_gone",  32'(dn_valid), 32'(0));

    // T5: stall the consumer with entries queued, then release
    dn_ready = 1'b0; req_valid = 4'b1111; req_data = 32'h0F1E2D3C;
    cycles(4);
    req_valid = '0;
    t5_dn = {dn_id, dn_data};
    cycles(3);
    chk("t5_stable", 32'({dn_id, dn_data}), 32'(t5_dn));
    dn_ready = 1'b1;
    cycles(5);

    // T6: queue entries, drop enable; the grant in the falling cycle completes, none after
    dn_ready = 1'b0; req_valid = 4'b1111; req_data = 32'h99887766;
    cycles(4);
    ctrl_enable = 1'b0;
    cycle();
    chk("t6_last_grant", 32'(last_ack != '0), 32'(1));
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_no_grant", 32'(last_ack), 32'(0));
    end
    dn_ready = 1'b1; req_valid = '0;
    for (int i = 0; i < 40 && ctrl_busy; i++) cycle();
    chk("t6_idle", 32'(ctrl_busy), 32'(0));

    // reset in the middle of a drain
    ctrl_enable = 1'b1; dn_ready = 1'b0; req_valid = 4'b1111;
    cycles(4);
    ctrl_enable = 1'b0; req_valid = '0;
    cycles(2);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_busy",  32'(ctrl_busy),  32'(0));
    chk("t6_rst_valid", 32'(dn_valid),   32'(0));
    chk("t6_rst_dn",    32'({dn_id, dn_data}), 32'(0));
    chk("t6_rst_pop",   32'(queue_pop),  32'(0));
    cycles(2);
    reset_n = 1'b1;

    // randomized traffic
    ctrl_enable = 1'b1;
    for (int i = 0; i < 500; i++) begin
      req_valid = NREQ'($urandom_range(0, 15));
      req_data  = $urandom;
      dn_ready  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) ctrl_enable = ~ctrl_enable;
      set_warn($urandom_range(0, 9) == 0);
      cycle();
    end

    // final drain
    set_warn(1'b0); ctrl_enable = 1'b0; req_valid = '0; dn_ready = 1'b1;
    for (int i = 0; i < 50 && ctrl_busy; i++) cycle();
    chk("final_idle", 32'(ctrl_busy), 32'(0));
    chk("final_exp_q_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
